// File: rtl/stepper_move.sv
// Button-triggered A4988 stepper mover: each debounced press runs one fixed-length move
// (STEPS pulses) clockwise (s1) or counter-clockwise (s2) and tracks the net signed position.
module stepper_move #(
  parameter int unsigned STEPS           = 100,
  parameter int unsigned STEP_HIGH_CYC   = 100,
  parameter int unsigned STEP_PERIOD_CYC = 50000,
  parameter int unsigned DIR_SETUP_CYC   = 50,
  parameter int unsigned DEBOUNCE_CYC    = 500000,
  parameter int unsigned POS_W           = 16
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             s1,
  input  logic             s2,
  output logic             dir,
  output logic             step,
  output logic             busy,
  output logic [POS_W-1:0] position,
  output logic             red,
  output logic             green,
  output logic             blue
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TMR_MAX = (DIR_SETUP_CYC > STEP_PERIOD_CYC) ? DIR_SETUP_CYC : STEP_PERIOD_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned REM_W   = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  // Button index 0 is s1 (cw), index 1 is s2 (ccw)
  logic [1:0]      meta_q, sync_q, stable_q, stable_d, press_c;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic [POS_W-1:0]   position_q, position_d, pos_step_c;
  logic               dir_q, dir_d;
  logic               step_q, busy_q, red_q, green_q, blue_q;

  // Debounce: stable value flips only after DEBOUNCE_CYC consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      stable_d[i] = stable_q[i];
      press_c[i]  = 1'b0;
      if (sync_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
          stable_d[i] = sync_q[i];
          press_c[i]  = ~sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      meta_q      <= 2'b11;
      sync_q      <= 2'b11;
      stable_q    <= 2'b11;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      meta_q      <= {s2, s1};
      sync_q      <= meta_q;
      stable_q    <= stable_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign pos_step_c = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));

  // Move sequencer; position and remaining update on every entry to HIGH
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    position_d  = position_q;
    unique case (state_q)
      IDLE: begin
        if (press_c[0] ^ press_c[1]) begin
          dir_d       = press_c[0];
          remaining_d = REM_W'(STEPS);
          timer_d     = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (timer_q == TMR_W'(DIR_SETUP_CYC - 1)) begin
          timer_d     = '0;
          state_d     = HIGH;
          position_d  = pos_step_c;
          remaining_d = remaining_q - REM_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HIGH: begin
        if (timer_q == TMR_W'(STEP_HIGH_CYC - 1)) begin
          timer_d = '0;
          state_d = LOW;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      LOW: begin
        if (timer_q == TMR_W'(STEP_PERIOD_CYC - STEP_HIGH_CYC - 1)) begin
          timer_d = '0;
          if (remaining_q != '0) begin
            state_d     = HIGH;
            position_d  = pos_step_c;
            remaining_d = remaining_q - REM_W'(1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      position_q  <= '0;
      dir_q       <= 1'b1;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      red_q       <= 1'b0;
      green_q     <= 1'b0;
      blue_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      position_q  <= position_d;
      dir_q       <= dir_d;
      step_q      <= (state_d == HIGH);
      busy_q      <= (state_d != IDLE);
      red_q       <= (state_d != IDLE) && dir_d;
      green_q     <= (state_d != IDLE) && !dir_d;
      blue_q      <= (state_d == IDLE);
    end
  end

  assign dir      = dir_q;
  assign step     = step_q;
  assign busy     = busy_q;
  assign position = position_q;
  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;

endmodule

// File: tb/tb_stepper_move.sv
// Scoreboard bench for stepper_move: each press pushes its expected step pulses,
// a negedge monitor pops and checks them against every observed step rise.
module tb_stepper_move;

  localparam int unsigned STEPS  = 3;
  localparam int unsigned HI_CYC = 2;
  localparam int unsigned PER    = 5;
  localparam int unsigned SETUP  = 2;
  localparam int unsigned DEB    = 4;
  localparam int unsigned POS_W  = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset_n;
  logic             s1, s2;
  logic             dir, step, busy, red, green, blue;
  logic [POS_W-1:0] position;

  typedef struct packed {
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             first;
  } exp_t;

  exp_t             sb [$];
  exp_t             mon_e;
  int               checks   = 0;
  int               failures = 0;
  int               cyc      = 0;
  int               busy_rise, last_rise;
  logic             step_prev = 1'b0;
  logic             busy_prev = 1'b0;
  logic             dir_mv;
  logic [POS_W-1:0] exp_pos = '0;

  stepper_move #(
    .STEPS(STEPS), .STEP_HIGH_CYC(HI_CYC), .STEP_PERIOD_CYC(PER),
    .DIR_SETUP_CYC(SETUP), .DEBOUNCE_CYC(DEB), .POS_W(POS_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .s1(s1), .s2(s2),
    .dir(dir), .step(step), .busy(busy), .position(position),
    .red(red), .green(green), .blue(blue)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Step/LED monitor
  always @(negedge CLOCK_50) begin
    checks++;
    if ({red, green, blue} !== {busy & dir, busy & ~dir, ~busy}) begin
      failures++;
      $display("FAIL leds: got rgb=%b%b%b busy=%b dir=%b", red, green, blue, busy, dir);
    end
    if (!reset_n) begin
      step_prev = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        busy_rise = cyc;
        dir_mv    = dir;
      end
      if (busy) begin
        checks++;
        if (dir !== dir_mv) begin
          failures++;
          $display("FAIL dir_hold: got %b required %b", dir, dir_mv);
        end
      end
      if (step && !step_prev) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_step: got rise at cyc %0d position=%0d required none", cyc, position);
        end else begin
          mon_e = sb.pop_front();
          if ({dir, position} !== {mon_e.dir, mon_e.pos}) begin
            failures++;
            $display("FAIL step_data: got dir=%b pos=%0d required dir=%b pos=%0d",
                     dir, position, mon_e.dir, mon_e.pos);
          end
          checks++;
          if (mon_e.first && (cyc - busy_rise) != int'(SETUP)) begin
            failures++;
            $display("FAIL setup_time: got %0d required %0d", cyc - busy_rise, SETUP);
          end else if (!mon_e.first && (cyc - last_rise) != int'(PER)) begin
            failures++;
            $display("FAIL step_period: got %0d required %0d", cyc - last_rise, PER);
          end
        end
        last_rise = cyc;
      end
      if (!step && step_prev) begin
        checks++;
        if ((cyc - last_rise) != int'(HI_CYC)) begin
          failures++;
          $display("FAIL step_high: got %0d required %0d", cyc - last_rise, HI_CYC);
        end
      end
      step_prev = step;
      busy_prev = busy;
    end
  end

  task automatic push_move(input logic d, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      exp_pos = d ? exp_pos + 4'd1 : exp_pos - 4'd1;
      e.dir   = d;
      e.pos   = exp_pos;
      e.first = (k == 0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_busy_hi(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_start_timeout: got busy=%b required 1", name, busy);
    end
  endtask

  task automatic wait_busy_lo(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end_timeout: got busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s1 = 1'b1; s2 = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({step, dir, busy, position, red, green, blue} !== {1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_state: got step=%b dir=%b busy=%b pos=%0d rgb=%b%b%b required 0 1 0 0 001",
               step, dir, busy, position, red, green, blue);
    end
    reset_n = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if ({busy, step, position} !== {1'b0, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b step=%b pos=%0d required 0 0 0", busy, step, position);
    end
  endtask

  task automatic test_cw();
    push_move(1'b1, 3);
    s1 = 1'b0;
    wait_busy_hi("cw");
    s1 = 1'b1;
    wait_busy_lo("cw");
    repeat (8) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, position, dir, blue} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL cw_move: got pending=%0d pos=%0d dir=%b blue=%b required 0 3 1 1",
               sb.size(), position, dir, blue);
    end
  endtask

  task automatic test_ccw();
    push_move(1'b0, 3);
    s2 = 1'b0;
    wait_busy_hi("ccw");
    s2 = 1'b1;
    checks++;
    if ({green, red, dir} !== 3'b100) begin
      failures++;
      $display("FAIL ccw_leds: got green=%b red=%b dir=%b required 1 0 0", green, red, dir);
    end
    wait_busy_lo("ccw");
    repeat (8) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, position, dir} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL ccw_move: got pending=%0d pos=%0d dir=%b required 0 0 0", sb.size(), position, dir);
    end
  endtask

  task automatic test_bounce();
    int lows [3]  = '{2, 3, 1};
    int highs [3] = '{1, 2, 1};
    s1 = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    s1 = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    checks++;
    if ({busy, position} !== {1'b0, exp_pos}) begin
      failures++;
      $display("FAIL short_bounce: got busy=%b pos=%0d required 0 %0d", busy, position, exp_pos);
    end
    push_move(1'b1, 3);
    for (int i = 0; i < 3; i++) begin
      s1 = 1'b0; repeat (lows[i]) @(negedge CLOCK_50);
      s1 = 1'b1; repeat (highs[i]) @(negedge CLOCK_50);
    end
    s1 = 1'b0;
    wait_busy_hi("bounce");
    s1 = 1'b1;
    wait_busy_lo("bounce");
    repeat (20) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, busy, position} !== {1'b1, 1'b0, exp_pos}) begin
      failures++;
      $display("FAIL bounce_move: got pending=%0d busy=%b pos=%0d required 0 0 %0d",
               sb.size(), busy, position, exp_pos);
    end
  endtask

  task automatic test_reject();
    push_move(1'b1, 3);
    s1 = 1'b0;
    wait_busy_hi("reject");
    s1 = 1'b1;
    s2 = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    s2 = 1'b1;
    wait_busy_lo("reject");
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, busy, position} !== {1'b1, 1'b0, exp_pos}) begin
      failures++;
      $display("FAIL press_during_move: got pending=%0d busy=%b pos=%0d required 0 0 %0d",
               sb.size(), busy, position, exp_pos);
    end
    s1 = 1'b0; s2 = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous_press: got busy=%b required 0", busy);
    end
    s1 = 1'b1; s2 = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if ({busy, position} !== {1'b0, exp_pos}) begin
      failures++;
      $display("FAIL simultaneous_release: got busy=%b pos=%0d required 0 %0d", busy, position, exp_pos);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    push_move(1'b1, 2);
    s1 = 1'b0;
    wait_busy_hi("reset_mid");
    s1 = 1'b1;
    while (sb.size() != 0 && n < 40) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (step !== 1'b1) begin
      failures++;
      $display("FAIL second_high: got step=%b required 1", step);
    end
    #2 reset_n = 1'b0;
    #1;
    exp_pos = '0;
    checks++;
    if ({step, position, busy, dir} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_abort: got step=%b pos=%0d busy=%b dir=%b required 0 0 0 1",
               step, position, busy, dir);
    end
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (30) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, busy, position} !== {1'b1, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL no_resume: got pending=%0d busy=%b pos=%0d required 0 0 0", sb.size(), busy, position);
    end
  endtask

  task automatic test_wrap();
    for (int m = 0; m < 6; m++) begin
      push_move(1'b0, 3);
      s2 = 1'b0;
      wait_busy_hi("wrap");
      s2 = 1'b1;
      wait_busy_lo("wrap");
      repeat (8) @(negedge CLOCK_50);
    end
    checks++;
    if ({sb.size() == 0, position} !== {1'b1, 4'b1110}) begin
      failures++;
      $display("FAIL wrap: got pending=%0d pos=%b required 0 1110", sb.size(), position);
    end
  endtask

  task automatic test_held_through_reset();
    int n = 0;
    reset_n = 1'b0;
    s2      = 1'b0;
    exp_pos = '0;
    push_move(1'b0, 3);
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    while (busy !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (n != int'(2 + DEB)) begin
      failures++;
      $display("FAIL held_press_latency: got %0d required %0d", n, 2 + DEB);
    end
    wait_busy_lo("held");
    repeat (30) @(negedge CLOCK_50);
    s2 = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if ({sb.size() == 0, busy, position} !== {1'b1, 1'b0, 4'hD}) begin
      failures++;
      $display("FAIL held_single_move: got pending=%0d busy=%b pos=%0d required 0 0 13",
               sb.size(), busy, position);
    end
  endtask

  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_bounce();
    test_reject();
    test_reset_mid();
    test_wrap();
    test_held_through_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
